fetch_unit: RTL and testbench

//  Decoupled, parametrised instruction-fetch front end for the next-generation RV32I pipeline.

---
 rtl/fetch_unit_pkg.sv | 21 ++
 rtl/fetch_unit_fifo.sv | 66 ++++++
 rtl/fetch_unit.sv | 175 +++++++++++++++++
 tb/tb_fetch_unit.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: queue entry layout,
// the NOP encoding used for misaligned markers and the fetch halt states.
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Queue entry layout: {pc, instruction, misaligned}
    localparam int FQ_MIS_BIT  = 0;
    localparam int FQ_DATA_LSB = 1;
    localparam int FQ_PC_LSB   = 33;

    typedef enum logic [0:0] {
        FETCH_RUN    = 1'b0,
        FETCH_HALTED = 1'b1
    } fetch_state_e;

    function automatic int fqEntryW(input int xlen);
        return xlen + 33;
    endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Synchronous fetch queue with flush. A flush empties the queue but may
// accept a push in the same cycle, which lands in slot 0.
module fetch_unit_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic                       clk,
    input  logic                       resetb,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           push_data_i,
    output logic [WIDTH-1:0]           head_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rdPtr_q;
    logic [PW-1:0]    wrPtr_q;
    logic [CW-1:0]    count_q;
    logic [PW-1:0]    wrIdx;
    logic             doPop;

    // Pop only a valid head; a flush restarts writing at slot 0
    always_comb begin
        doPop = pop_i && (count_q != '0);
        wrIdx = flush_i ? PW'(0) : wrPtr_q;
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (!resetb) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            rdPtr_q <= '0;
            wrPtr_q <= push_i ? PW'(1) : PW'(0);
            count_q <= push_i ? CW'(1) : CW'(0);
        end else begin
            if (push_i) begin
                wrPtr_q <= wrPtr_q + PW'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
            count_q <= count_q + CW'(push_i) - CW'(doPop);
        end
    end

    // Entry storage needs no reset; occupancy decides what is visible
    always_ff @(posedge clk) begin
        if (resetb && push_i) begin
            mem_q[wrIdx] <= push_data_i;
        end
    end

    assign head_data_o = mem_q[rdPtr_q];
    assign count_o     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction-fetch front end. Requests go out on a valid/ready
// channel, responses return in order and are queued with their PC for decode.
// Issue is credit-limited so the queue can always absorb every live response.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              DEPTH        = 4,
    parameter int              MAX_INFLIGHT = 2,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            resetb,
    output logic            im_req_valid,
    input  logic            im_req_ready,
    output logic [XLEN-1:0] im_req_addr,
    input  logic            im_rsp_valid,
    input  logic [31:0]     im_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fd_valid,
    input  logic            fd_ready,
    output logic [31:0]     fd_inst,
    output logic [XLEN-1:0] fd_pc,
    output logic            fd_misaligned
);

    localparam int EW = fqEntryW(XLEN);
    localparam int IW = $clog2(MAX_INFLIGHT+1);
    localparam int CW = $clog2(DEPTH+1);

    fetch_state_e    state_q, state_d;
    logic            halted;
    logic [XLEN-1:0] fetchPc_q, fetchPc_d;
    logic [XLEN-1:0] rspPc_q, rspPc_d;
    logic [IW-1:0]   live_q, live_d;
    logic [IW-1:0]   discard_q, discard_d;

    logic            redirMis;
    logic            haltedEff;
    logic [CW-1:0]   countEff;
    logic [IW-1:0]   liveEff;
    logic            reqValid;
    logic [XLEN-1:0] reqAddr;
    logic            handshake;
    logic            rspKeep;
    logic [IW-1:0]   rspSub;

    logic            fifoPush;
    logic            fifoPop;
    logic [EW-1:0]   fifoPushData;
    logic [EW-1:0]   fifoHead;
    logic [CW-1:0]   fifoCount;

    // Issue decision: a redirect takes effect immediately on the request path
    always_comb begin
        redirMis  = redirect_pc[1:0] != 2'b00;
        haltedEff = redirect_valid ? redirMis : halted;
        countEff  = redirect_valid ? CW'(0) : fifoCount;
        liveEff   = redirect_valid ? IW'(0) : live_q;
        reqAddr   = redirect_valid ? redirect_pc : fetchPc_q;
        reqValid  = resetb && !haltedEff
                    && ((int'(live_q) + int'(discard_q)) < MAX_INFLIGHT)
                    && ((int'(countEff) + int'(liveEff)) < DEPTH);
        handshake = reqValid && im_req_ready;
        rspKeep   = im_rsp_valid && !redirect_valid && (discard_q == '0) && (live_q != '0);
        rspSub    = (im_rsp_valid && ((live_q != '0) || (discard_q != '0))) ? IW'(1) : IW'(0);
    end

    // Queue control: a redirect flushes and may enqueue a misaligned marker
    always_comb begin
        fifoPush     = redirect_valid ? redirMis : rspKeep;
        fifoPop      = !redirect_valid && fd_ready && (fifoCount != '0);
        fifoPushData = redirect_valid ? {redirect_pc, NOP_INST, 1'b1}
                                      : {rspPc_q, im_rsp_data, 1'b0};
    end

    // Next fetch PC, response PC and in-flight/discard counters
    always_comb begin
        fetchPc_d = fetchPc_q;
        rspPc_d   = rspPc_q;
        live_d    = live_q;
        discard_d = discard_q;
        if (redirect_valid) begin
            discard_d = discard_q + live_q - rspSub;
            live_d    = handshake ? IW'(1) : IW'(0);
            fetchPc_d = handshake ? redirect_pc + XLEN'(4) : redirect_pc;
            rspPc_d   = redirect_pc;
        end else begin
            if (handshake) begin
                live_d    = live_q + IW'(1);
                fetchPc_d = fetchPc_q + XLEN'(4);
            end
            if (im_rsp_valid) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - IW'(1);
                end else if (live_q != '0) begin
                    live_d  = live_d - IW'(1);
                    rspPc_d = rspPc_q + XLEN'(4);
                end
            end
        end
    end

    // Datapath registers, cleared to the reset vector on reset
    always_ff @(posedge clk) begin
        if (!resetb) begin
            fetchPc_q <= RESET_VECTOR;
            rspPc_q   <= RESET_VECTOR;
            live_q    <= '0;
            discard_q <= '0;
        end else begin
            fetchPc_q <= fetchPc_d;
            rspPc_q   <= rspPc_d;
            live_q    <= live_d;
            discard_q <= discard_d;
        end
    end

    // Halt state register
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q <= FETCH_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Only a redirect changes the halt state; its alignment decides which way
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = redirMis ? FETCH_HALTED : FETCH_RUN;
        end
    end

    // Halt state output
    always_comb begin
        halted = (state_q == FETCH_HALTED);
    end

    fetch_unit_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk         (clk),
        .resetb      (resetb),
        .flush_i     (redirect_valid),
        .push_i      (fifoPush),
        .pop_i       (fifoPop),
        .push_data_i (fifoPushData),
        .head_data_o (fifoHead),
        .count_o     (fifoCount)
    );

    // All outputs are forced low while reset is asserted
    always_comb begin
        im_req_valid  = reqValid;
        im_req_addr   = resetb ? reqAddr : '0;
        fd_valid      = resetb && (fifoCount != '0);
        fd_inst       = resetb ? fifoHead[FQ_DATA_LSB +: 32] : '0;
        fd_pc         = resetb ? fifoHead[FQ_PC_LSB +: XLEN] : '0;
        fd_misaligned = resetb && fd_valid && fifoHead[FQ_MIS_BIT];
    end

    // Bookkeeping invariants of the credit scheme
    always @(posedge clk) begin
        if (resetb) begin
            assert ((int'(live_q) + int'(discard_q)) <= MAX_INFLIGHT);
            assert (int'(fifoCount) <= DEPTH);
            assert (!(im_rsp_valid && (live_q == '0) && (discard_q == '0)));
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, credit back-pressure, redirects,
// misaligned markers, and address wrap with a non-zero reset vector.
module tb_fetch_unit;

    logic        clk;
    logic        resetb;
    logic        im_req_ready;
    logic        im_rsp_valid;
    logic [31:0] im_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fd_ready;
    logic        im_req_valid;
    logic [31:0] im_req_addr;
    logic        fd_valid;
    logic [31:0] fd_inst;
    logic [31:0] fd_pc;
    logic        fd_misaligned;

    logic        im_req_ready2;
    logic        im_rsp_valid2;
    logic [31:0] im_rsp_data2;
    logic        im_req_valid2;
    logic [31:0] im_req_addr2;
    logic        fd_valid2;
    logic [31:0] fd_inst2;
    logic [31:0] fd_pc2;
    logic        fd_misaligned2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pending[$];
    logic [31:0] reqLog[$];
    int          memLat = 1;
    int          cyc    = 0;
    logic        pend2;
    logic [31:0] pend2Addr;
    logic        got;

    fetch_unit dut (
        .clk            (clk),
        .resetb         (resetb),
        .im_req_valid   (im_req_valid),
        .im_req_ready   (im_req_ready),
        .im_req_addr    (im_req_addr),
        .im_rsp_valid   (im_rsp_valid),
        .im_rsp_data    (im_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fd_valid       (fd_valid),
        .fd_ready       (fd_ready),
        .fd_inst        (fd_inst),
        .fd_pc          (fd_pc),
        .fd_misaligned  (fd_misaligned)
    );

    fetch_unit #(.RESET_VECTOR(32'hFFFF_FFF8)) dut2 (
        .clk            (clk),
        .resetb         (resetb),
        .im_req_valid   (im_req_valid2),
        .im_req_ready   (im_req_ready2),
        .im_req_addr    (im_req_addr2),
        .im_rsp_valid   (im_rsp_valid2),
        .im_rsp_data    (im_rsp_data2),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .fd_valid       (fd_valid2),
        .fd_ready       (1'b1),
        .fd_inst        (fd_inst2),
        .fd_pc          (fd_pc2),
        .fd_misaligned  (fd_misaligned2)
    );

    function automatic logic [31:0] memData(input logic [31:0] addr);
        return addr ^ 32'hDEAD_0000;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Starts a cycle: drive inputs at the falling edge, settle, then return for checks
    task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic fr);
        @(negedge clk);
        resetb         = 1'b1;
        redirect_valid = rv;
        redirect_pc    = rpc;
        fd_ready       = fr;
        #1;
    endtask

    task automatic doReset(input int lat);
        @(negedge clk);
        resetb         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        fd_ready       = 1'b0;
        memLat         = lat;
        @(negedge clk);
        #1;
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    // Memory for the main DUT: in-order responses after a programmable latency
    initial begin
        im_rsp_valid = 1'b0;
        im_rsp_data  = 32'h0;
        forever begin
            @(negedge clk);
            if (pending.size() > 0 && pending[0].due <= cyc) begin
                im_rsp_valid = 1'b1;
                im_rsp_data  = memData(pending[0].addr);
            end else begin
                im_rsp_valid = 1'b0;
                im_rsp_data  = 32'h0;
            end
            #3;
            if (!resetb) begin
                pending.delete();
            end else begin
                if (im_rsp_valid) begin
                    void'(pending.pop_front());
                end
                if (im_req_valid && im_req_ready) begin
                    pending.push_back('{im_req_addr, cyc + memLat});
                    reqLog.push_back(im_req_addr);
                end
            end
            cyc++;
        end
    end

    // Latency-1 memory for the wrap-around DUT
    initial begin
        im_rsp_valid2 = 1'b0;
        im_rsp_data2  = 32'h0;
        pend2         = 1'b0;
        pend2Addr     = 32'h0;
        forever begin
            @(negedge clk);
            im_rsp_valid2 = pend2;
            im_rsp_data2  = pend2 ? memData(pend2Addr) : 32'h0;
            #3;
            pend2     = resetb && im_req_valid2 && im_req_ready2;
            pend2Addr = im_req_addr2;
        end
    end

    initial begin
        resetb         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        fd_ready       = 1'b0;
        im_req_ready   = 1'b1;
        im_req_ready2  = 1'b1;

        // Reset state and latency-1 streaming
        doReset(1);
        checkOutput("rst req_valid", im_req_valid, 1'b0);
        checkOutput("rst req_addr", im_req_addr, 32'h0);
        checkOutput("rst fd_valid", fd_valid, 1'b0);
        checkOutput("rst fd_pc", fd_pc, 32'h0);
        checkOutput("rst fd_inst", fd_inst, 32'h0);
        checkOutput("rst fd_mis", fd_misaligned, 1'b0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b1);
            checkOutput($sformatf("t1 req_valid c%0d", k), im_req_valid, 1'b1);
            checkOutput($sformatf("t1 req_addr c%0d", k), im_req_addr, 32'(4 * k));
            if (k >= 2) begin
                checkOutput($sformatf("t1 fd_valid c%0d", k), fd_valid, 1'b1);
                checkOutput($sformatf("t1 fd_pc c%0d", k), fd_pc, 32'(4 * (k - 2)));
                checkOutput($sformatf("t1 fd_inst c%0d", k), fd_inst, memData(32'(4 * (k - 2))));
            end else begin
                checkOutput($sformatf("t1 fd_valid c%0d", k), fd_valid, 1'b0);
            end
        end

        // Redirect coincident with a response and a pop
        applyStimulus(1'b1, 32'h300, 1'b1);
        checkOutput("t4 req_valid", im_req_valid, 1'b1);
        checkOutput("t4 req_addr", im_req_addr, 32'h300);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("t4 queue empty", fd_valid, 1'b0);
        checkOutput("t4 next addr", im_req_addr, 32'h304);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("t4 fd_valid", fd_valid, 1'b1);
        checkOutput("t4 fd_pc", fd_pc, 32'h300);
        checkOutput("t4 fd_inst", fd_inst, memData(32'h300));

        // Credit limit with latency 3 and a stalled decode
        doReset(3);
        reqLog.delete();
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b0);
        end
        checkOutput("t2 req count", reqLog.size(), 4);
        checkOutput("t2 last addr", reqLog[3], 32'hC);
        checkOutput("t2 req_valid idle", im_req_valid, 1'b0);
        checkOutput("t2 fd_valid", fd_valid, 1'b1);
        checkOutput("t2 head pc", fd_pc, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 15; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b0);
        end
        checkOutput("t2 req count after pop", reqLog.size(), 5);
        checkOutput("t2 new addr", reqLog[4], 32'h10);
        checkOutput("t2 req_valid idle2", im_req_valid, 1'b0);
        checkOutput("t2 head pc after pop", fd_pc, 32'h4);

        // Redirect discards two in-flight responses
        doReset(3);
        applyStimulus(1'b1, 32'h10, 1'b0);
        checkOutput("t3 req0 valid", im_req_valid, 1'b1);
        checkOutput("t3 req0 addr", im_req_addr, 32'h10);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("t3 req1 addr", im_req_addr, 32'h14);
        applyStimulus(1'b1, 32'h100, 1'b0);
        checkOutput("t3 blocked", im_req_valid, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0);
            got = fd_valid;
        end
        checkOutput("t3 fd_valid wait", got, 1'b1);
        checkOutput("t3 fd_pc", fd_pc, 32'h100);
        checkOutput("t3 fd_inst", fd_inst, memData(32'h100));
        checkOutput("t3 fd_mis", fd_misaligned, 1'b0);

        // Misaligned redirect halts fetch until the next redirect
        doReset(1);
        applyStimulus(1'b1, 32'h102, 1'b0);
        checkOutput("t5 no req", im_req_valid, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("t5 fd_valid", fd_valid, 1'b1);
        checkOutput("t5 fd_pc", fd_pc, 32'h102);
        checkOutput("t5 fd_mis", fd_misaligned, 1'b1);
        checkOutput("t5 fd_inst", fd_inst, 32'h13);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b0);
            checkOutput($sformatf("t5 halted c%0d", k), im_req_valid, 1'b0);
        end
        applyStimulus(1'b1, 32'h200, 1'b0);
        checkOutput("t5 resume valid", im_req_valid, 1'b1);
        checkOutput("t5 resume addr", im_req_addr, 32'h200);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("t5 flushed", fd_valid, 1'b0);
        checkOutput("t5 next addr", im_req_addr, 32'h204);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("t5 new pc", fd_pc, 32'h200);
        checkOutput("t5 new mis", fd_misaligned, 1'b0);
        checkOutput("t5 new inst", fd_inst, memData(32'h200));

        // Non-zero reset vector, address wrap and reset mid-stream
        doReset(1);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("t6 addr c0", im_req_addr2, 32'hFFFF_FFF8);
        checkOutput("t6 valid c0", im_req_valid2, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("t6 addr c1", im_req_addr2, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("t6 addr c2", im_req_addr2, 32'h0);
        checkOutput("t6 fd_pc c2", fd_pc2, 32'hFFFF_FFF8);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("t6 fd_pc c3", fd_pc2, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("t6 fd_pc c4", fd_pc2, 32'h0);
        checkOutput("t6 fd_inst c4", fd_inst2, memData(32'h0));
        @(negedge clk);
        resetb = 1'b0;
        #1;
        checkOutput("t6 rst valid", im_req_valid2, 1'b0);
        checkOutput("t6 rst addr", im_req_addr2, 32'h0);
        checkOutput("t6 rst fd_valid", fd_valid2, 1'b0);
        checkOutput("t6 rst fd_pc", fd_pc2, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("t6 restart addr", im_req_addr2, 32'hFFFF_FFF8);
        checkOutput("t6 restart valid", im_req_valid2, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("t6 restart fd_pc", fd_pc2, 32'hFFFF_FFF8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
